// File: rtl/tb_clock_sequencer.sv
// Run-control sequencer for the inverted-clock generator channels.
// Stores timing words, staggers channel bring-up and shuts down together.
module tb_clock_sequencer #(
  parameter int NUM_CLK = 4,
  parameter int DLY_W   = 16,
  parameter int DRAIN   = 8
) (
  input  logic                   CLK,
  input  logic                   RSTn,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [2:0]             cfg_chan,
  input  logic [3:0]             cfg_idx,
  input  logic [63:0]            cfg_data,
  input  logic                   start,
  input  logic                   stop,
  output logic                   busy,
  output logic [NUM_CLK-1:0]     err,
  output logic [2*NUM_CLK-1:0]   tb_status,
  output logic [NUM_CLK*576-1:0] timing_bits
);

  localparam int DCW = (DRAIN < 2) ? 1 : $clog2(DRAIN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ENABLE,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         ch_q, ch_d;
  logic [DLY_W-1:0]   dly_q, dly_d;
  logic [DCW-1:0]     drn_q, drn_d;
  logic [NUM_CLK-1:0] run_q, run_d;
  logic [NUM_CLK-1:0] lock_q, lock_d;
  logic [NUM_CLK-1:0] err_q, err_d;
  logic [NUM_CLK-1:0] valid_q, valid_d;
  logic [63:0]        word_q [NUM_CLK][9];
  logic [63:0]        word_d [NUM_CLK][9];
  logic [DLY_W-1:0]   delay_q [NUM_CLK];
  logic [DLY_W-1:0]   delay_d [NUM_CLK];

  logic               wr;
  logic [NUM_CLK-1:0] bad;
  logic [DLY_W-1:0]   nxt_dly;

  assign cfg_ready = (state_q == S_IDLE) & RSTn;
  assign wr        = cfg_valid & cfg_ready;
  assign busy      = (state_q != S_IDLE);
  assign err       = err_q;

  // Config storage update; out-of-range addresses fall through untouched
  always_comb begin
    word_d  = word_q;
    delay_d = delay_q;
    for (int c = 0; c < NUM_CLK; c++) begin
      for (int k = 0; k < 9; k++) begin
        if (wr && cfg_chan == 3'(c) && cfg_idx == 4'(k))
          word_d[c][k] = cfg_data;
      end
      if (wr && cfg_chan == 3'(c) && cfg_idx == 4'd9)
        delay_d[c] = cfg_data[DLY_W-1:0];
    end
  end

  // Period/duty <= 0.0 detection on the raw IEEE-754 images
  always_comb begin
    bad = '0;
    for (int c = 0; c < NUM_CLK; c++) begin
      bad[c] = word_q[c][1][63] | (word_q[c][1][62:0] == '0) |
               word_q[c][2][63] | (word_q[c][2][62:0] == '0);
    end
  end

  // Delay of the channel following the current one
  always_comb begin
    nxt_dly = '0;
    for (int c = 0; c < NUM_CLK; c++) begin
      if (ch_q + 3'd1 == 3'(c))
        nxt_dly = delay_q[c];
    end
  end

  // Sequencer next-state and run/lock control
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    dly_d   = dly_q;
    drn_d   = drn_q;
    run_d   = run_q;
    lock_d  = lock_q;
    err_d   = err_q;
    valid_d = valid_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          state_d = S_ENABLE;
          ch_d    = '0;
          dly_d   = delay_q[0];
          lock_d  = '1;
          err_d   = bad;
          valid_d = ~bad;
        end
      end
      S_ENABLE: begin
        if (stop) begin
          run_d   = '0;
          drn_d   = DCW'(DRAIN - 1);
          state_d = S_DRAIN;
        end else if (dly_q != '0) begin
          dly_d = dly_q - DLY_W'(1);
        end else begin
          for (int c = 0; c < NUM_CLK; c++) begin
            if (ch_q == 3'(c) && valid_q[c])
              run_d[c] = 1'b1;
          end
          if (ch_q == 3'(NUM_CLK - 1)) begin
            state_d = S_RUN;
          end else begin
            ch_d  = ch_q + 3'd1;
            dly_d = nxt_dly;
          end
        end
      end
      S_RUN: begin
        if (stop) begin
          run_d   = '0;
          drn_d   = DCW'(DRAIN - 1);
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drn_q == '0) begin
          lock_d  = '0;
          state_d = S_IDLE;
        end else begin
          drn_d = drn_q - DCW'(1);
        end
      end
    endcase
  end

  // State and storage registers
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
      dly_q   <= '0;
      drn_q   <= '0;
      run_q   <= '0;
      lock_q  <= '0;
      err_q   <= '0;
      valid_q <= '0;
      word_q  <= '{default: '0};
      delay_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      dly_q   <= dly_d;
      drn_q   <= drn_d;
      run_q   <= run_d;
      lock_q  <= lock_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      word_q  <= word_d;
      delay_q <= delay_d;
    end
  end

  // Flatten status pairs and timing words onto the output buses
  always_comb begin
    tb_status   = '0;
    timing_bits = '0;
    for (int c = 0; c < NUM_CLK; c++) begin
      tb_status[2*c]   = run_q[c];
      tb_status[2*c+1] = lock_q[c];
      for (int k = 0; k < 9; k++)
        timing_bits[576*c+64*k +: 64] = word_q[c][k];
    end
  end

endmodule
